// File: rtl/residual_coeff_place_pkg.sv
// Shared defines for residual coefficient placement: FSM encoding, residual
// state codes and block geometry.
package residual_coeff_place_pkg;

  localparam int NUM_COEFF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } place_state_t;

  // Residual state codes carried alongside each block for the downstream stage.
  typedef enum logic [3:0] {
    RES_LUMA_LEVEL          = 4'd0,
    RES_INTRA16X16_DC_LEVEL = 4'd1,
    RES_INTRA16X16_AC_LEVEL = 4'd2,
    RES_CB_LEVEL            = 4'd3,
    RES_CB_INTRA16X16_DC    = 4'd4,
    RES_CB_INTRA16X16_AC    = 4'd5,
    RES_CR_LEVEL            = 4'd6,
    RES_CR_INTRA16X16_DC    = 4'd7,
    RES_CR_INTRA16X16_AC    = 4'd8,
    RES_CHROMA_DC_LEVEL_CB  = 4'd9,
    RES_CHROMA_DC_LEVEL_CR  = 4'd10,
    RES_CHROMA_AC_LEVEL_CB  = 4'd11,
    RES_CHROMA_AC_LEVEL_CR  = 4'd12
  } residual_state_t;

endpackage

// File: rtl/residual_coeff_place_conv.sv
// residual_level_conv: LEVEL_W -> COEFF_W level conversion.
// LEVEL_SAT_EN defined: saturate to the signed COEFF_W range; otherwise truncate.
module residual_level_conv #(
  parameter int LEVEL_W = 16,
  parameter int COEFF_W = 12
) (
  input  logic signed [LEVEL_W-1:0] level,
  output logic signed [COEFF_W-1:0] coeff
);
`ifdef LEVEL_SAT_EN
  localparam logic signed [LEVEL_W-1:0] SAT_MAX = LEVEL_W'((1 << (COEFF_W-1)) - 1);
  localparam logic signed [LEVEL_W-1:0] SAT_MIN = -LEVEL_W'(1 << (COEFF_W-1));

  always_comb begin
    coeff = level[COEFF_W-1:0];
    if (level > SAT_MAX)      coeff = SAT_MAX[COEFF_W-1:0];
    else if (level < SAT_MIN) coeff = SAT_MIN[COEFF_W-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^level[LEVEL_W-1:COEFF_W];
  assign coeff     = level[COEFF_W-1:0];
`endif
endmodule

// File: rtl/residual_coeff_place.sv
// Places CAVLC level/run_before pairs into a 16-entry scan-order array and
// hands the finished block downstream. Level conversion set by LEVEL_SAT_EN.
module residual_coeff_place
  import residual_coeff_place_pkg::*;
#(
  parameter int LEVEL_W = 16,
  parameter int COEFF_W = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [4:0]                total_coeff,
  input  logic [3:0]                total_zeros,
  input  logic [4:0]                max_coeff_num,
  input  logic [3:0]                residual_state_in,
  output logic                      busy,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [LEVEL_W-1:0] level,
  input  logic [3:0]                run_before,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3:0]                residual_state_out,
  output logic signed [COEFF_W-1:0] coeff_0,  coeff_1,  coeff_2,  coeff_3,
  output logic signed [COEFF_W-1:0] coeff_4,  coeff_5,  coeff_6,  coeff_7,
  output logic signed [COEFF_W-1:0] coeff_8,  coeff_9,  coeff_10, coeff_11,
  output logic signed [COEFF_W-1:0] coeff_12, coeff_13, coeff_14, coeff_15,
  output logic                      err
);

  place_state_t              state_q;
  logic signed [5:0]         pos_q;
  logic [4:0]                remaining_q;
  logic                      err_q;
  logic [3:0]                rs_q;
  logic signed [COEFF_W-1:0] coeff_q [NUM_COEFF];
  logic signed [COEFF_W-1:0] conv_out;

  residual_level_conv #(.LEVEL_W(LEVEL_W), .COEFF_W(COEFF_W)) u_conv (
    .level (level),
    .coeff (conv_out)
  );

  logic [5:0]        zsum;
  logic              start_err;
  logic signed [6:0] pos_nxt;

  assign zsum      = {1'b0, total_coeff} + {2'b00, total_zeros};
  assign start_err = (total_coeff > max_coeff_num) || (zsum > {1'b0, max_coeff_num});
  // One extra bit so an underflow below zero is seen before truncation.
  assign pos_nxt   = {pos_q[5], pos_q} - {3'b000, run_before} - 7'sd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      remaining_q <= '0;
      err_q       <= 1'b0;
      rs_q        <= '0;
      for (int k = 0; k < NUM_COEFF; k++) coeff_q[k] <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start) begin
          for (int k = 0; k < NUM_COEFF; k++) coeff_q[k] <= '0;
          rs_q        <= residual_state_in;
          pos_q       <= zsum - 6'd1;
          remaining_q <= total_coeff;
          err_q       <= start_err;
          if (start_err || total_coeff == 5'd0) state_q <= ST_DONE;
          else                                  state_q <= ST_FILL;
        end
        ST_FILL: if (in_valid) begin
          // Range guard covers max_coeff_num values beyond the array size.
          if (!err_q && pos_q[5:4] == 2'b00) coeff_q[pos_q[3:0]] <= conv_out;
          pos_q       <= pos_nxt[5:0];
          remaining_q <= remaining_q - 5'd1;
          if (pos_nxt[6] && remaining_q > 5'd1) err_q <= 1'b1;
          if (remaining_q == 5'd1) state_q <= ST_DONE;
        end
        ST_DONE: if (out_ready) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy               = (state_q != ST_IDLE);
  assign in_ready           = (state_q == ST_FILL);
  assign out_valid          = (state_q == ST_DONE);
  assign err                = err_q;
  assign residual_state_out = rs_q;

  assign coeff_0  = coeff_q[0];   assign coeff_1  = coeff_q[1];
  assign coeff_2  = coeff_q[2];   assign coeff_3  = coeff_q[3];
  assign coeff_4  = coeff_q[4];   assign coeff_5  = coeff_q[5];
  assign coeff_6  = coeff_q[6];   assign coeff_7  = coeff_q[7];
  assign coeff_8  = coeff_q[8];   assign coeff_9  = coeff_q[9];
  assign coeff_10 = coeff_q[10];  assign coeff_11 = coeff_q[11];
  assign coeff_12 = coeff_q[12];  assign coeff_13 = coeff_q[13];
  assign coeff_14 = coeff_q[14];  assign coeff_15 = coeff_q[15];

endmodule

// File: tb/tb_residual_coeff_place.sv
// Directed-vector bench for residual_coeff_place; expectations hand-computed.
module tb_residual_coeff_place;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  total_coeff = '0;
  logic [3:0]  total_zeros = '0;
  logic [4:0]  max_coeff_num = '0;
  logic [3:0]  residual_state_in = '0;
  logic        busy, in_ready, out_valid, err;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic signed [15:0] level = '0;
  logic [3:0]  run_before = '0;
  logic [3:0]  residual_state_out;
  logic signed [11:0] c [16];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  residual_coeff_place dut (
    .clk(clk), .rst(rst), .start(start), .total_coeff(total_coeff),
    .total_zeros(total_zeros), .max_coeff_num(max_coeff_num),
    .residual_state_in(residual_state_in), .busy(busy), .in_valid(in_valid),
    .in_ready(in_ready), .level(level), .run_before(run_before),
    .out_valid(out_valid), .out_ready(out_ready),
    .residual_state_out(residual_state_out),
    .coeff_0(c[0]),   .coeff_1(c[1]),   .coeff_2(c[2]),   .coeff_3(c[3]),
    .coeff_4(c[4]),   .coeff_5(c[5]),   .coeff_6(c[6]),   .coeff_7(c[7]),
    .coeff_8(c[8]),   .coeff_9(c[9]),   .coeff_10(c[10]), .coeff_11(c[11]),
    .coeff_12(c[12]), .coeff_13(c[13]), .coeff_14(c[14]), .coeff_15(c[15]),
    .err(err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic blk_start(input int tc, input int tz, input int mx, input int rs);
    total_coeff = 5'(tc); total_zeros = 4'(tz); max_coeff_num = 5'(mx);
    residual_state_in = 4'(rs); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pair(input int lv, input int rb);
    in_valid = 1'b1; level = 16'(lv); run_before = 4'(rb);
    step();
    in_valid = 1'b0;
  endtask

  // Compares every coefficient against an expected table; one vector per block.
  task automatic chk_all(input string tag, input int exp [16]);
    int bad = 0;
    for (int k = 0; k < 16; k++)
      if (int'(c[k]) != exp[k]) begin
        bad++;
        $display("FAIL %s: coeff_%0d got %0d expected %0d", tag, k, int'(c[k]), exp[k]);
      end
    chk({tag, "_badcount"}, bad, 0);
  endtask

  int exp_c [16];
  int seen_ready;
  int changed;
  int nz;

  initial begin
    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_rs", residual_state_out, 0);
    exp_c = '{default: 0};
    chk_all("rst_coeff", exp_c);
    @(negedge clk); rst = 1'b0;
    step();

    // Basic block: pos starts at 4
    blk_start(3, 2, 16, 5);
    chk("b1_in_ready", in_ready, 1);
    chk("b1_busy", busy, 1);
    pair(5, 1);
    pair(-2, 0);
    chk("b1_not_done", out_valid, 0);
    pair(1, 9);
    chk("b1_out_valid", out_valid, 1);
    chk("b1_in_ready_lo", in_ready, 0);
    chk("b1_err", err, 0);
    chk("b1_rs", residual_state_out, 5);
    exp_c = '{default: 0};
    exp_c[4] = 5; exp_c[2] = -2; exp_c[1] = 1;
    chk_all("b1", exp_c);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("b1_back_idle", busy, 0);

    // Empty block, held output
    blk_start(0, 0, 15, 2);
    chk("empty_out_valid", out_valid, 1);
    chk("empty_err", err, 0);
    exp_c = '{default: 0};
    chk_all("empty", exp_c);
    changed = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!out_valid || residual_state_out != 4'd2) changed++;
      for (int k = 0; k < 16; k++) if (c[k] != 0) changed++;
    end
    chk("empty_hold", changed, 0);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Start-time error: 4 + 1 > 4
    seen_ready = 0;
    blk_start(4, 1, 4, 9);
    if (in_ready) seen_ready++;
    chk("serr_out_valid", out_valid, 1);
    chk("serr_err", err, 1);
    step();
    if (in_ready) seen_ready++;
    chk("serr_no_ready", seen_ready, 0);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Run error: pos 1 - 2 - 1 < 0 with a pair still pending
    blk_start(2, 0, 16, 0);
    pair(3, 2);
    chk("rerr_err_early", err, 1);
    chk("rerr_still_ready", in_ready, 1);
    pair(7, 0);
    chk("rerr_out_valid", out_valid, 1);
    chk("rerr_err", err, 1);
    exp_c = '{default: 0};
    exp_c[1] = 3;
    chk_all("rerr", exp_c);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Out-of-range levels
    blk_start(2, 0, 16, 1);
    pair(3000, 0);
    pair(-3000, 0);
    chk("sat_err", err, 0);
    exp_c = '{default: 0};
`ifdef LEVEL_SAT_EN
    exp_c[1] = 2047; exp_c[0] = -2048;
`else
    exp_c[1] = -1096; exp_c[0] = 1096;
`endif
    chk_all("conv", exp_c);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Reset mid-FILL after 2 of 5 pairs
    blk_start(5, 0, 16, 7);
    pair(9, 0);
    pair(8, 0);
    rst = 1'b1;
    step();
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_err", err, 0);
    chk("mrst_rs", residual_state_out, 0);
    nz = 0;
    for (int k = 0; k < 16; k++) if (c[k] != 0) nz++;
    chk("mrst_coeff_nz", nz, 0);
    rst = 1'b0;
    step();
    chk("mrst_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/residual_coeff_place.md
# residual_coeff_place

Run/level placement stage between the CAVLC residual decoder and `transform_inverse_zigzag`. Accepts one block's nonzero levels with their run_before values, serially in decode order (highest scan position first). Writes each level into a 16-entry scan-order coefficient array and presents the completed array with a valid/ready handshake. Coefficient index k equals scan position k, counted from the first coded coefficient; AC blocks therefore occupy coeff_0..coeff_14.

## Interface
- LEVEL_W, 16, signed width of incoming level values
- COEFF_W, 12, signed width of output coefficients
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle block start; sampled only in IDLE
- total_coeff  in  5  nonzero count for the block (0..16); sampled with start
- total_zeros  in  4  zeros preceding the last nonzero coefficient; sampled with start
- max_coeff_num  in  5  block capacity: 4 (chroma DC), 15 (AC), 16 (luma 4x4/DC); sampled with start
- residual_state_in  in  4  residual state code; sampled with start
- busy  out  1  high whenever state is not IDLE
- in_valid  in  1  level/run_before pair valid
- in_ready  out  1  high in FILL only
- level  in  LEVEL_W  signed level value
- run_before  in  4  zeros between this level and the next lower coded position
- out_valid  out  1  coefficient array complete and held
- out_ready  in  1  consumer accepts the array
- residual_state_out  out  4  latched residual_state_in
- coeff_0 … coeff_15  out  COEFF_W each  registered coefficients in scan order
- err  out  1  block malformed; valid alongside out_valid

## Operation
- States: IDLE, FILL, DONE.
- IDLE, start=1:
  - Clear all coeff_k, err, and the remaining-pair counter.
  - Latch residual_state_out.
  - Set pos = total_coeff + total_zeros − 1, using a 6-bit signed internal.
- Start-time error: if total_coeff > max_coeff_num or total_coeff + total_zeros > max_coeff_num, set err=1 and go to DONE with all coefficients zero.
- Empty block: if total_coeff = 0 with no start-time error, go to DONE with all coefficients zero and err=0.
- Otherwise go to FILL with remaining = total_coeff.
- FILL, each accepted pair (in_valid & in_ready):
  - If err=0, write coeff[pos] = conv(level).
  - Then pos ← pos − run_before − 1 and remaining ← remaining − 1.
  - The run_before of the final pair is ignored.
- Run error: if the updated pos would be < 0 while remaining > 1, set err=1. Later writes are suppressed, but pairs are still consumed until remaining reaches 0.
- Accepting the last pair moves the state to DONE.
- DONE: out_valid=1 and all outputs are held stable. out_valid & out_ready → IDLE. Coefficients keep their values until the next start.
- start is ignored outside IDLE.
- conv(): see Configuration.

## Timing
- Reset values: state IDLE; busy, in_ready, out_valid, err = 0; coeff_0..15 = 0; residual_state_out = 0.
- rst is asynchronous: any state returns to IDLE immediately, and any partial block is discarded.
- Start edge → FILL in the next cycle, so in_ready=1 one cycle after start.
- Throughput: one pair per cycle. Latency from the last pair accepted to out_valid=1 is 1 cycle.
- total_coeff = 0, or a start-time error: out_valid=1 one cycle after start.
- Minimum block period: total_coeff + 2 cycles when out_ready is held high.
- in_ready and out_valid are decoded from the state register only; neither depends combinationally on any input.

## Configuration
- LEVEL_SAT_EN defined: conv() saturates level to the signed COEFF_W range, [−2048, 2047] for COEFF_W = 12.
- LEVEL_SAT_EN undefined: conv() keeps the low COEFF_W bits (truncation). The logic is otherwise identical.

## Structure
- The FSM state encodings and the residual_state codes (Intra16x16ACLevel_s, ChromaDCLevel_Cb_s, etc.) go in the shared defines file, not in this module.
- One sub-module, `residual_level_conv`: combinational LEVEL_W → COEFF_W conversion, with saturation under LEVEL_SAT_EN. Its result feeds the write port of the coefficient array.

## Test plan
- Reset mid-FILL, after 2 of 5 pairs → next cycle: busy=0, in_ready=0, all coefficients 0, err=0.
- start with total_coeff=3, total_zeros=2, max=16; pairs (5,1), (−2,0), (1,x) → coeff_4=5, coeff_2=−2, coeff_1=1, others 0, out_valid one cycle after the third pair.
- start with total_coeff=0, max=15 → out_valid next cycle, all 16 coefficients 0, err=0. Holding out_ready=0 for 10 cycles keeps out_valid=1 and the outputs stable.
- start with total_coeff=4, total_zeros=1, max=4 → err=1 and out_valid next cycle; in_ready never asserted.
- total_coeff=2, total_zeros=0; pair (3, run_before=2) → err=1, second pair still consumed, coeff_1=3 and coeff_0=0.
- level=3000 with LEVEL_SAT_EN → coefficient 2047. Without LEVEL_SAT_EN → 3000 mod 4096 read as signed, i.e. −1096.
